axi_wrr_arbiter: RTL and testbench
==================================

Name: axi_wrr_arbiter

Overview:
- Weighted round-robin arbiter for NUM_REQ AXI masters sharing one slave-side channel.
- Arbitrates once per transaction, not per cycle. The winner's grant is held until the last beat of its burst completes.
- A master may win up to weight[i] consecutive transactions before the priority pointer rotates past it.
- Sits in front of the shared AW/AR mux. Successor of the 2-input per-cycle round-robin arbiter.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WEIGHT_W, 4, width of each per-requester weight/credit field.
- TIMEOUT_CYC, 256, cycles allowed in BUSY before forced release; used only with ARB_HOLD_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  request per master; must stay high until its last transfer.
- req_last  in  NUM_REQ  last-beat flag per master; only the granted master's bit is sampled.
- xfer  in  1  beat handshake (valid&ready) on the shared channel this cycle.
- weight  in  NUM_REQ*WEIGHT_W  static per-master weight; field i is bits [i*WEIGHT_W +: WEIGHT_W]; 0 is treated as 1.
- grant  out  NUM_REQ  one-hot grant, registered.
- grant_valid  out  1  high when grant is non-zero.
- grant_idx  out  $clog2(NUM_REQ)  binary index of grant; 0 when idle.
- timeout_err  out  1  one-cycle pulse on forced release (ARB_HOLD_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; grant=0, grant_valid=0, grant_idx=0, timeout_err=0.
  - Pointer mask = all ones, so index 0 has highest priority.
  - credit = weight[0] (0 is treated as 1); timer = 0.
  - Reset mid-burst drops the grant immediately, asynchronously.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If |req, pick a winner, register it into grant, and go to BUSY.
  - Latency is exactly 1 cycle from req sampled to grant visible.
  - If req=0, stay in IDLE; pointer and credit are unchanged.
- Pick rule:
  - masked = req & pointer_mask.
  - If masked != 0, the winner is the lowest set bit of masked; otherwise the winner is the lowest set bit of req.
  - pointer_mask is "all bits above the current owner". When the pointer wraps past NUM_REQ-1, the mask becomes all ones.
- BUSY:
  - grant is held constant.
  - Completion is xfer && req_last[g] in the same cycle (g = granted index).
  - On completion, decrement credit:
    - If the new credit is 0, advance pointer_mask to the bits above g, then reload credit from the weight of the next winner at its next grant.
    - Otherwise the pointer stays on g, so g wins again if it is still requesting.
  - On completion, deassert grant the next cycle and return to IDLE. There is always one idle bubble cycle between transactions.
- Abort: if req[g] falls while BUSY without completion:
  - Treat it as a completion with credit forced to 0: pointer advances, return to IDLE.
  - No error is flagged.
- Credit reload:
  - Whenever a winner differs from the previous owner, credit = max(weight[winner], 1).
- Non-granted traffic: xfer with req_last is ignored in IDLE; req_last bits of non-granted masters are ignored.
- Simultaneous events: completion and a new request from a higher-priority master in the same cycle produce no preemption. The new request is arbitrated in the following IDLE cycle.
- All outputs are driven from flops; there is no combinational path from req to grant.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A timer counts cycles in BUSY and is cleared on entry to BUSY.
  - If the timer reaches TIMEOUT_CYC-1 without completion, force a release exactly as an abort, and pulse timeout_err for 1 cycle, coincident with grant falling.
- Undefined: no timer logic; timeout_err is tied 0; grant is held indefinitely.

Decomposition:
- Package arb_pkg:
  - arb_state_e enum {ARB_IDLE, ARB_BUSY}.
  - Localparam helper for the index width ($clog2).
  - Function onehot_to_idx.
- Sub-module arb_rr_pick:
  - Combinational masked/unmasked lowest-set-bit picker.
  - Inputs: req, pointer_mask. Outputs: one-hot winner, next_mask (bits above winner).
  - Instantiated once; the pointer and credit registers stay in the parent.

Test Plan:
- Reset then req=4'b1111, all weights=1, each burst 1 beat -> grants in order 0001, 0010, 0100, 1000, 0001. Each grant lasts 1 cycle, with 1 idle cycle between grants.
- weight[0]=3, others=1, req=4'b0011 held, single-beat bursts -> grant sequence 0,0,0,1,0,0,0,1.
- Master 2 granted, 4-beat burst with xfer every other cycle -> grant stays 0100 for 8 cycles. grant=0 in the cycle after the beat carrying req_last[2].
- Master 1 granted, req[1] dropped after 2 beats with no last -> grant=0 next cycle. The next winner with req=4'b0011 is master 0 (pointer past 1, wrap).
- rst asserted mid-burst while grant=0100 -> grant=0 without waiting for a clock edge. After release with req=4'b0100, master 2 is granted 1 cycle later.
- ARB_HOLD_TIMEOUT_EN, TIMEOUT_CYC=16, granted master never asserts last -> timeout_err pulses in BUSY cycle 16 and grant clears. Without the macro, grant holds for 1000 cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the weighted round-robin arbiter.
//   arb_state_e   : arbiter FSM states (IDLE / BUSY).
//   idx_width()   : index width for a requester count (at least 1 bit).
//   onehot_to_idx : binary index of a one-hot vector (up to MAX_REQ bits).
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OR of the indices of all set bits; exact for a one-hot input and
  // cheaper than a priority encoder.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin picker.
//   req          in  NUM_REQ  request vector
//   pointer_mask in  NUM_REQ  requesters still eligible in this round
//   winner       out NUM_REQ  one-hot winner (lowest set bit of the masked
//                             requests, else lowest set bit of req)
//   next_mask    out NUM_REQ  bits strictly above the winner; all ones on wrap
module arb_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] pointer_mask,
  output logic [NUM_REQ-1:0] winner,
  output logic [NUM_REQ-1:0] next_mask
);

  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pool;
  logic [NUM_REQ-1:0] w_le;

  always_comb begin
    w_masked  = req & pointer_mask;
    w_pool    = (|w_masked) ? w_masked : req;
    // Two's-complement trick isolates the lowest set bit.
    winner    = w_pool & (~w_pool + NUM_REQ'(1));
    // Ones at and below the winner; inverted gives the bits above it.
    w_le      = (winner << 1) - NUM_REQ'(1);
    next_mask = ~w_le;
    if (next_mask == '0) next_mask = '1;
  end

endmodule

// File: rtl/axi_wrr_arbiter.sv
// axi_wrr_arbiter: per-transaction weighted round-robin arbiter placed in
// front of the shared AW/AR mux. A winner keeps its grant until the last beat
// of its burst and may win up to weight[i] consecutive transactions.
//   clk, rst     : clock, asynchronous active-high reset
//   req          : per-master request, held until its last transfer
//   req_last     : per-master last-beat flag (granted bit only)
//   xfer         : beat handshake on the shared channel
//   weight       : packed per-master weights, field i at [i*WEIGHT_W +: WEIGHT_W]
//   grant        : registered one-hot grant
//   grant_valid  : grant is non-zero
//   grant_idx    : binary index of grant, 0 when idle
//   timeout_err  : one-cycle pulse on forced release
// Optional: define ARB_HOLD_TIMEOUT_EN to force release after TIMEOUT_CYC
// busy cycles; otherwise timeout_err is tied low and grants are held forever.
module axi_wrr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WEIGHT_W    = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          xfer,
  input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          grant_valid,
  output logic [idx_width(NUM_REQ)-1:0] grant_idx,
  output logic                          timeout_err
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_grant_valid;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [NUM_REQ-1:0]  r_mask;
  logic [NUM_REQ-1:0]  r_above;
  logic [WEIGHT_W-1:0] r_credit;
  logic [IDX_W-1:0]    r_owner;
  logic                r_reload;

  logic [NUM_REQ-1:0]  w_win;
  logic [NUM_REQ-1:0]  w_next_mask;
  logic [IDX_W-1:0]    w_win_idx;
  logic [WEIGHT_W-1:0] w_win_wt;
  logic                w_cur_req;
  logic                w_done;
  logic                w_timeout;
  logic                w_release;
  logic                w_abort;

  arb_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req          (req),
    .pointer_mask (r_mask),
    .winner       (w_win),
    .next_mask    (w_next_mask)
  );

  always_comb begin
    w_win_idx = IDX_W'(onehot_to_idx(MAX_REQ'(w_win)));
    w_win_wt  = weight[w_win_idx*WEIGHT_W +: WEIGHT_W];
    if (w_win_wt == '0) w_win_wt = WEIGHT_W'(1);
    w_cur_req = |(req & r_grant);
    w_done    = (r_state == ARB_BUSY) && xfer && (|(req_last & r_grant));
    w_abort   = (r_state == ARB_BUSY) && !w_done && (!w_cur_req || w_timeout);
    w_release = w_done || w_abort;
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int TMR_W = idx_width(TIMEOUT_CYC);

  logic [TMR_W-1:0] r_timer;
  logic             r_timeout_err;

  always_comb begin
    w_timeout = (r_state == ARB_BUSY) && w_cur_req && !w_done &&
                (r_timer == TMR_W'(TIMEOUT_CYC - 1));
  end

  // Timer rests at 0 outside BUSY, so it reads 0 on the first busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state != ARB_BUSY || w_release) r_timer <= '0;
      else                                  r_timer <= r_timer + TMR_W'(1);
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_tmo;

  always_comb begin
    w_timeout = 1'b0;
  end

  assign w_unused_tmo = (TIMEOUT_CYC == 0);
  assign timeout_err  = 1'b0;
`endif

  // Credit is not reset to weight[0]; instead r_reload forces a load on the
  // first grant, which is observably identical and keeps reset values constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_mask        <= '1;
      r_above       <= '1;
      r_credit      <= '0;
      r_owner       <= '0;
      r_reload      <= 1'b1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|req) begin
            r_grant       <= w_win;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_win_idx;
            r_above       <= w_next_mask;
            r_owner       <= w_win_idx;
            if (r_reload || (w_win_idx != r_owner)) begin
              r_credit <= w_win_wt;
              r_reload <= 1'b0;
            end
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_release) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_state       <= ARB_IDLE;
            if (w_abort || (r_credit <= WEIGHT_W'(1))) begin
              r_credit <= '0;
              r_reload <= 1'b1;
              r_mask   <= r_above;
            end else begin
              r_credit <= r_credit - WEIGHT_W'(1);
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_axi_wrr_arbiter.sv
// tb_axi_wrr_arbiter: directed self-checking bench for axi_wrr_arbiter.
module tb_axi_wrr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic        xfer;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic        timeout_err;

  int unsigned n_chk;
  int unsigned n_err;

  axi_wrr_arbiter #(
    .NUM_REQ     (4),
    .WEIGHT_W    (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_last    (req_last),
    .xfer        (xfer),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req      = '0;
    req_last = '0;
    xfer     = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Check grant plus the derived outputs for an expected one-hot (or zero).
  task automatic chk_grant(input string tag, input logic [3:0] exp_g);
    logic [1:0] exp_i;
    exp_i = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_g[i]) exp_i = 2'(i);
    chk({tag, ".grant"}, 32'(grant), 32'(exp_g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(exp_g != 4'b0000));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(exp_i));
  endtask

  logic [3:0] exp1 [10];
  logic [3:0] exp2 [8];
  logic       held;

  initial begin
    n_chk  = 0;
    n_err  = 0;
    weight = 16'h0101;
    rst    = 1'b1;
    req      = '0;
    req_last = '0;
    xfer     = 1'b0;
    #2;
    chk_grant("reset", 4'b0000);
    chk("reset.tmo", 32'(timeout_err), 32'd0);
    do_reset();

    // Rotation with effective weights of 1 (fields of 0 count as 1).
    exp1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
             4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    req = 4'b1111; req_last = 4'b1111; xfer = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_grant($sformatf("rot%0d", i), exp1[i]);
    end
    req = '0; xfer = 1'b0;
    tick();
    chk_grant("idle_noreq", 4'b0000);

    // Weight 3 on master 0.
    weight = 16'h1113;
    do_reset();
    exp2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
             4'b0001, 4'b0001, 4'b0001, 4'b0010};
    req = 4'b0011; req_last = 4'b0011; xfer = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_grant($sformatf("wt%0d", i), exp2[i]);
      tick();
      chk_grant($sformatf("wt%0d.gap", i), 4'b0000);
    end

    // Master 2, 4-beat burst with a beat every other cycle; other masters'
    // last bits are high and must be ignored. Master 0 arrives on the last beat.
    weight = 16'h1111;
    do_reset();
    req = 4'b0100; req_last = 4'b1011; xfer = 1'b0;
    tick();
    chk_grant("burst.c1", 4'b0100);
    for (int c = 1; c <= 8; c++) begin
      xfer = (c % 2 == 0);
      req_last[2] = (c == 8);
      if (c == 8) req = 4'b0101;
      tick();
      if (c < 8) chk_grant($sformatf("burst.c%0d", c + 1), 4'b0100);
      else       chk_grant("burst.end", 4'b0000);
    end
    req = 4'b0001; req_last = '0; xfer = 1'b0;
    tick();
    chk_grant("burst.next", 4'b0001);

    // Abort: master 1 drops req after two beats without last.
    do_reset();
    req = 4'b0010;
    tick();
    chk_grant("abort.g", 4'b0010);
    xfer = 1'b1;
    tick();
    chk_grant("abort.b1", 4'b0010);
    tick();
    chk_grant("abort.b2", 4'b0010);
    xfer = 1'b0; req = 4'b0001;
    tick();
    chk_grant("abort.rel", 4'b0000);
    chk("abort.tmo", 32'(timeout_err), 32'd0);
    req = 4'b0011;
    tick();
    chk_grant("abort.wrap", 4'b0001);

    // Asynchronous reset mid-burst.
    do_reset();
    req = 4'b0100;
    tick();
    chk_grant("arst.g", 4'b0100);
    tick();
    chk_grant("arst.hold", 4'b0100);
    #3 rst = 1'b1;
    #1;
    chk_grant("arst.drop", 4'b0000);
    tick();
    rst = 1'b0;
    chk_grant("arst.rel", 4'b0000);
    tick();
    chk_grant("arst.regrant", 4'b0100);

    // Master never signals last.
    do_reset();
    req = 4'b0001; xfer = 1'b0;
    tick();
    chk_grant("hold.g", 4'b0001);
`ifdef ARB_HOLD_TIMEOUT_EN
    held = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (grant !== 4'b0001 || timeout_err !== 1'b0) held = 1'b0;
    end
    chk("tmo.held", 32'(held), 32'd1);
    tick();
    chk_grant("tmo.rel", 4'b0000);
    chk("tmo.pulse", 32'(timeout_err), 32'd1);
    tick();
    chk("tmo.pulse_end", 32'(timeout_err), 32'd0);
    chk_grant("tmo.regrant", 4'b0001);
`else
    held = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (grant !== 4'b0001 || timeout_err !== 1'b0) held = 1'b0;
    end
    chk("hold.1000", 32'(held), 32'd1);
    chk_grant("hold.end", 4'b0001);
`endif
    req = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
